// File: rtl/cnn_pkg.sv
// cnn_pkg: definitions shared by the CNN datapath stages (conv, dense, argmax).
//   DATA_WIDTH_DEFAULT : default logit / activation width
//   S_MAX, S_MIN       : signed saturation limits at the default width
//   state_t            : 2-bit scan FSM encoding used by the argmax stage
package cnn_pkg;

  localparam int DATA_WIDTH_DEFAULT = 16;

  localparam logic signed [DATA_WIDTH_DEFAULT-1:0] S_MAX =
    {1'b0, {(DATA_WIDTH_DEFAULT-1){1'b1}}};
  localparam logic signed [DATA_WIDTH_DEFAULT-1:0] S_MIN =
    {1'b1, {(DATA_WIDTH_DEFAULT-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/top2_update.sv
// top2_update: combinational step of a running best / second-best tracker.
//   best, best_i, second : current tracker contents
//   v, i                 : candidate value and its class index
//   best_next, best_i_next, second_next : tracker after considering v
// Comparisons are strict, so an equal later value never displaces the
// current best; it can only become the second-best (margin 0 on ties).
module top2_update
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int IDX_W      = 4
) (
  input  logic signed [DATA_WIDTH-1:0] best,
  input  logic        [IDX_W-1:0]      best_i,
  input  logic signed [DATA_WIDTH-1:0] second,
  input  logic signed [DATA_WIDTH-1:0] v,
  input  logic        [IDX_W-1:0]      i,
  output logic signed [DATA_WIDTH-1:0] best_next,
  output logic        [IDX_W-1:0]      best_i_next,
  output logic signed [DATA_WIDTH-1:0] second_next
);

  always_comb begin
    best_next   = best;
    best_i_next = best_i;
    second_next = second;
    if (v > best) begin
      // old best slides down to second place
      second_next = best;
      best_next   = v;
      best_i_next = i;
    end else if (v > second) begin
      second_next = v;
    end
  end

endmodule

// File: rtl/argmax_top2.sv
// argmax_top2: classification stage after the fully-connected layer.
// On start the logits are snapshotted and scanned one per cycle, tracking
// the best and second-best score. Results are committed in one cycle and
// held until the next completed run.
//   clk       : clock, rising edge
//   reset     : synchronous, active-high
//   start     : one-cycle run request (accepted only while idle)
//   in_vec    : NUM_CLASSES signed logits
//   class_idx : index of the maximum logit (lowest index on ties)
//   max_val   : maximum logit
//   margin    : max_val minus second-best, unsigned
//   busy      : run in progress (low again in the done cycle)
//   done      : one-cycle pulse, outputs valid in that cycle
//   valid     : sticky, set by the first done after reset
module argmax_top2
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_W       = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic signed [DATA_WIDTH-1:0] in_vec [0:NUM_CLASSES-1],
  output logic        [IDX_W-1:0]      class_idx,
  output logic signed [DATA_WIDTH-1:0] max_val,
  output logic        [DATA_WIDTH-1:0] margin,
  output logic                        busy,
  output logic                        done,
  output logic                        valid
);

  // Most negative value at this instance's width; the tracker starts here so
  // any real logit (including the minimum itself) can occupy second place.
  localparam logic signed [DATA_WIDTH-1:0] SCAN_MIN =
    {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_t state_reg;
  state_t state_next;

  logic signed [DATA_WIDTH-1:0] snap_reg [0:NUM_CLASSES-1];
  logic        [IDX_W-1:0]      i_reg;
  logic signed [DATA_WIDTH-1:0] best_reg;
  logic        [IDX_W-1:0]      best_i_reg;
  logic signed [DATA_WIDTH-1:0] second_reg;

  logic signed [DATA_WIDTH-1:0] best_next;
  logic        [IDX_W-1:0]      best_i_next;
  logic signed [DATA_WIDTH-1:0] second_next;
  logic        [DATA_WIDTH-1:0] margin_next;

  logic        [IDX_W-1:0]      class_idx_reg;
  logic signed [DATA_WIDTH-1:0] max_val_reg;
  logic        [DATA_WIDTH-1:0] margin_reg;
  logic                         busy_reg;
  logic                         done_reg;
  logic                         valid_reg;

  top2_update #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_update (
    .best        (best_reg),
    .best_i      (best_i_reg),
    .second      (second_reg),
    .v           (snap_reg[i_reg]),
    .i           (i_reg),
    .best_next   (best_next),
    .best_i_next (best_i_next),
    .second_next (second_next)
  );

  // best >= second always holds, so the true difference lies in
  // [0, 2^DATA_WIDTH-1]; its low DATA_WIDTH bits are exactly the modular
  // DATA_WIDTH-bit difference, with no wrap in the unsigned reading.
  assign margin_next = DATA_WIDTH'(best_reg - second_reg);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SCAN;
      SCAN:    if (i_reg == LAST_IDX) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      class_idx_reg <= '0;
      max_val_reg   <= '0;
      margin_reg    <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      valid_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            snap_reg   <= in_vec;
            i_reg      <= '0;
            best_reg   <= SCAN_MIN;
            best_i_reg <= '0;
            second_reg <= SCAN_MIN;
            busy_reg   <= 1'b1;
          end
        end
        SCAN: begin
          best_reg   <= best_next;
          best_i_reg <= best_i_next;
          second_reg <= second_next;
          if (i_reg != LAST_IDX) begin
            i_reg <= i_reg + IDX_W'(1);
          end
        end
        FINISH: begin
          class_idx_reg <= best_i_reg;
          max_val_reg   <= best_reg;
          margin_reg    <= margin_next;
          done_reg      <= 1'b1;
          valid_reg     <= 1'b1;
          busy_reg      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign class_idx = class_idx_reg;
  assign max_val   = max_val_reg;
  assign margin    = margin_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign valid     = valid_reg;

endmodule

// File: tb/tb_argmax_top2.sv
module tb_argmax_top2;

  localparam int DW = 16;
  localparam int N  = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic                 start;
  logic signed [DW-1:0] in_vec [0:N-1];
  logic [3:0]           class_idx;
  logic signed [DW-1:0] max_val;
  logic [DW-1:0]        margin;
  logic                 busy, done, valid;

  logic                 start_1;
  logic signed [DW-1:0] in_vec_1 [0:0];
  logic [0:0]           class_idx_1;
  logic signed [DW-1:0] max_val_1;
  logic [DW-1:0]        margin_1;
  logic                 busy_1, done_1, valid_1;

  int compared   = 0;
  int mismatched = 0;

  argmax_top2 #(.DATA_WIDTH(DW), .NUM_CLASSES(N)) dut (
    .clk(clk), .reset(reset), .start(start), .in_vec(in_vec),
    .class_idx(class_idx), .max_val(max_val), .margin(margin),
    .busy(busy), .done(done), .valid(valid)
  );

  argmax_top2 #(.DATA_WIDTH(DW), .NUM_CLASSES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start_1), .in_vec(in_vec_1),
    .class_idx(class_idx_1), .max_val(max_val_1), .margin(margin_1),
    .busy(busy_1), .done(done_1), .valid(valid_1)
  );

  task automatic check(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: winner is the first occurrence of the maximum; second is the
  // largest of the remaining elements (or the minimum value if none remain).
  function automatic void model(input int vals[N], input int n,
                                output int bi, output int bv, output int mg);
    int sec;
    bi = 0;
    for (int k = 1; k < n; k++) if (vals[k] > vals[bi]) bi = k;
    bv  = vals[bi];
    sec = -(1 << (DW - 1));
    for (int k = 0; k < n; k++) if (k != bi && vals[k] > sec) sec = vals[k];
    mg = bv - sec;
  endfunction

  task automatic launch(input int vals[N]);
    for (int k = 0; k < N; k++) in_vec[k] = DW'(vals[k]);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic await_done(input string tag, input int exp_edges);
    int edges = 0;
    while (done !== 1'b1 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check({tag, " latency"}, edges, exp_edges);
    check({tag, " busy_in_done"}, int'(busy), 0);
  endtask

  task automatic expect_out(input string tag, input int idx, input int val, input int mg);
    $display("run %s: class_idx=%0d max_val=%0d margin=%0d", tag, class_idx, max_val, margin);
    check({tag, " class_idx"}, int'(class_idx), idx);
    check({tag, " max_val"}, int'(max_val), val);
    check({tag, " margin"}, int'(margin), mg);
    check({tag, " valid"}, int'(valid), 1);
  endtask

  task automatic no_done_for(input string tag, input int cycles);
    int seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    check({tag, " stray_done"}, seen, 0);
  endtask

  initial begin
    int a[N];
    int b[N];
    int bi, bv, mg;
    int edges;

    reset = 1'b1; start = 1'b0; start_1 = 1'b0;
    for (int k = 0; k < N; k++) in_vec[k] = '0;
    in_vec_1[0] = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("reset class_idx", int'(class_idx), 0);
    check("reset max_val", int'(max_val), 0);
    check("reset margin", int'(margin), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset valid", int'(valid), 0);

    // Distinct values
    a = '{5, -3, 120, 7, 0, -128, 64, 1, 2, 3};
    launch(a);
    check("distinct busy_after_start", int'(busy), 1);
    check("distinct valid_before_done", int'(valid), 0);
    await_done("distinct", N + 1);
    expect_out("distinct", 2, 120, 56);
    @(posedge clk); #1;
    check("distinct done_one_cycle", int'(done), 0);

    // Tie: lowest index wins, margin 0
    for (int k = 0; k < N; k++) a[k] = -10;
    a[4] = 300; a[8] = 300;
    launch(a);
    await_done("tie", N + 1);
    expect_out("tie", 4, 300, 0);

    // Extremes
    for (int k = 0; k < N; k++) a[k] = -32768;
    a[9] = 32767;
    launch(a);
    await_done("extreme_max", N + 1);
    expect_out("extreme_max", 9, 32767, 65535);
    for (int k = 0; k < N; k++) a[k] = -32768;
    launch(a);
    await_done("extreme_min", N + 1);
    expect_out("extreme_min", 0, -32768, 0);

    // Ignored mid-scan start and snapshot isolation, then back-to-back
    for (int k = 0; k < N; k++) a[k] = int'($urandom_range(0, 65535)) - 32768;
    model(a, N, bi, bv, mg);
    launch(a);
    repeat (3) begin @(posedge clk); #1; end
    for (int k = 0; k < N; k++) in_vec[k] = DW'($urandom);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < N; k++) in_vec[k] = DW'($urandom);
    await_done("snapshot", N + 1 - 4);
    expect_out("snapshot", bi, bv, mg);
    for (int k = 0; k < N; k++) b[k] = int'($urandom_range(0, 200)) - 100;
    model(b, N, bi, bv, mg);
    launch(b);
    check("b2b busy", int'(busy), 1);
    await_done("b2b", N + 1);
    expect_out("b2b", bi, bv, mg);
    no_done_for("b2b", 15);

    // Reset mid-scan
    launch(a);
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midreset class_idx", int'(class_idx), 0);
    check("midreset max_val", int'(max_val), 0);
    check("midreset margin", int'(margin), 0);
    check("midreset valid", int'(valid), 0);
    check("midreset busy", int'(busy), 0);
    no_done_for("midreset", 15);
    model(b, N, bi, bv, mg);
    launch(b);
    await_done("after_reset", N + 1);
    expect_out("after_reset", bi, bv, mg);

    // Randomized runs; narrow ranges force frequent ties
    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < N; k++)
        a[k] = (r % 2 == 0) ? int'($urandom_range(0, 65535)) - 32768
                            : int'($urandom_range(0, 4)) - 2;
      model(a, N, bi, bv, mg);
      launch(a);
      await_done($sformatf("rand%0d", r), N + 1);
      expect_out($sformatf("rand%0d", r), bi, bv, mg);
    end

    // Single-class instance
    for (int r = 0; r < 4; r++) begin
      a[0] = (r == 0) ? -7 : int'($urandom_range(0, 65535)) - 32768;
      in_vec_1[0] = DW'(a[0]);
      start_1 = 1'b1;
      @(posedge clk); #1;
      start_1 = 1'b0;
      edges = 0;
      while (done_1 !== 1'b1 && edges < 20) begin
        @(posedge clk); #1;
        edges++;
      end
      $display("run n1_%0d: class_idx=%0d max_val=%0d margin=%0d", r, class_idx_1, max_val_1, margin_1);
      check("n1 latency", edges, 2);
      check("n1 class_idx", int'(class_idx_1), 0);
      check("n1 max_val", int'(max_val_1), a[0]);
      check("n1 margin", int'(margin_1), a[0] + 32768);
      check("n1 valid", int'(valid_1), 1);
      check("n1 busy_in_done", int'(busy_1), 0);
    end
    check("n1 directed margin", 32761, -7 + 32768);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
